// File: rtl/axil_pkg.sv
// Shared response codes and FSM state types for the AXI4-Lite register file.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

endpackage

// File: rtl/axil_addr_decode.sv
// Combinational address decode: register index plus range/privilege error.
// Privilege checking is compiled in only with AXIL_REG_FILE_PROT_EN.
module axil_addr_decode
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int PRIV_BASE  = 8
) (
    input  logic [ADDR_WIDTH-1:0]       addr_i,
    input  logic [2:0]                  prot_i,
    output logic [$clog2(NUM_REGS)-1:0] idx_o,
    output logic                        err_o
);

    localparam int OW = $clog2(DATA_WIDTH / 8);
    localparam int IW = $clog2(NUM_REGS);

    logic range_err;
    logic priv_err;
    logic unused_bits;

    assign idx_o     = addr_i[OW +: IW];
    assign range_err = |(addr_i >> (OW + IW));

`ifdef AXIL_REG_FILE_PROT_EN
    // Only prot[0] (privileged) matters; secure/instruction bits are ignored.
    assign priv_err    = ~prot_i[0] &&
                         ($unsigned(32'(idx_o)) >= $unsigned(32'(PRIV_BASE)));
    assign unused_bits = ^{addr_i[OW-1:0], prot_i[2:1]};
`else
    assign priv_err    = 1'b0;
    assign unused_bits = ^{addr_i[OW-1:0], prot_i};
`endif

    assign err_o = range_err | priv_err;

endmodule

// File: rtl/axil_reg_file.sv
// AXI4-Lite slave register file with strobed writes and write pulses.
// Optional privilege checks enabled by defining AXIL_REG_FILE_PROT_EN.
module axil_reg_file
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int PRIV_BASE  = 8
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic [2:0]                     s_axi_awprot,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic [2:0]                     s_axi_arprot,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
    output logic [NUM_REGS-1:0]            reg_wr_o
);

    localparam int IW = $clog2(NUM_REGS);
    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   reg_wr_q;

    w_state_t              w_state_q;
    logic                  aw_held_q;
    logic                  w_held_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [2:0]            aw_prot_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [NB-1:0]         w_strb_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;

    r_state_t              r_state_q;
    logic                  rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [IW-1:0]         w_idx;
    logic                  w_err;
    logic [IW-1:0]         r_idx;
    logic                  r_err;

    axil_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .PRIV_BASE  (PRIV_BASE)
    ) u_wdec (
        .addr_i (aw_addr_q),
        .prot_i (aw_prot_q),
        .idx_o  (w_idx),
        .err_o  (w_err)
    );

    axil_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .PRIV_BASE  (PRIV_BASE)
    ) u_rdec (
        .addr_i (s_axi_araddr),
        .prot_i (s_axi_arprot),
        .idx_o  (r_idx),
        .err_o  (r_err)
    );

    assign s_axi_awready = ~aw_held_q & ~bvalid_q;
    assign s_axi_wready  = ~w_held_q & ~bvalid_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = (r_state_q == R_IDLE);
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign reg_wr_o      = reg_wr_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign reg_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            aw_prot_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            reg_wr_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            reg_wr_q <= '0;
            if (s_axi_awvalid && s_axi_awready) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= s_axi_awaddr;
                aw_prot_q <= s_axi_awprot;
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_held_q <= 1'b1;
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end
            unique case (w_state_q)
                W_IDLE: begin
                    if (aw_held_q && w_held_q) begin
                        if (!w_err) begin
                            for (int b = 0; b < NB; b++) begin
                                if (w_strb_q[b]) begin
                                    regs_q[w_idx][b*8 +: 8] <= w_data_q[b*8 +: 8];
                                end
                            end
                            reg_wr_q[w_idx] <= 1'b1;
                            bresp_q         <= RESP_OKAY;
                        end else begin
                            bresp_q <= RESP_SLVERR;
                        end
                        bvalid_q  <= 1'b1;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_q  <= 1'b0;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Reads sample regs_q before any same-edge commit, so they see old data.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            unique case (r_state_q)
                R_IDLE: begin
                    if (s_axi_arvalid) begin
                        rdata_q   <= r_err ? '0 : regs_q[r_idx];
                        rresp_q   <= r_err ? RESP_SLVERR : RESP_OKAY;
                        rvalid_q  <= 1'b1;
                        r_state_q <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        rvalid_q  <= 1'b0;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_reg_file.sv
// Self-checking bench for axil_reg_file against an array-based register model.
module tb_axil_reg_file;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [31:0]  awaddr = '0;
    logic [2:0]   awprot = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [31:0]  araddr = '0;
    logic [2:0]   arprot = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [511:0] reg_o;
    logic [15:0]  reg_wr_o;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [31:0] m_regs [16];

    always #5 aclk = ~aclk;

    always @(negedge aclk) pulses <= pulses + $countones(reg_wr_o);

    axil_reg_file dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (awprot),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .reg_o         (reg_o),
        .reg_wr_o      (reg_wr_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_err(input logic [31:0] a, input logic [2:0] p);
        bit e;
        e = (a / 4) >= 16;
`ifdef AXIL_REG_FILE_PROT_EN
        if (((a / 4) >= 8) && !p[0]) e = 1'b1;
`else
        if (p == 3'b111) e = e;
`endif
        return e;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < 16; i++) check(tag, reg_o[i*32 +: 32], m_regs[i]);
    endtask

    task automatic wait_ready(input string tag, input bit aw, input bit w, input bit ar);
        int n;
        n = 0;
        while (!((!aw || awready) && (!w || wready) && (!ar || arready)) && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check({tag, "_ready_timeout"}, n < 20, 1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] p,
                      input logic [31:0] d, input logic [3:0] s);
        bit e;
        int idx;
        int p0;
        e = m_err(a, p);
        idx = (a / 4) % 16;
        @(negedge aclk);
        awaddr = a; awprot = p; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        bready = 1'b1;
        wait_ready("wr", 1, 1, 0);
        p0 = pulses;
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge aclk);
        check("wr_bvalid_t1", bvalid, 0);
        @(negedge aclk);
        check("wr_bvalid_t2", bvalid, 1);
        check("wr_bresp", bresp, e ? 2'b10 : 2'b00);
        check("wr_pulse_bit", reg_wr_o, e ? 16'h0 : (16'h1 << idx));
        if (!e) m_regs[idx] = merge(m_regs[idx], d, s);
        check("wr_reg", reg_o[idx*32 +: 32], m_regs[idx]);
        @(posedge aclk); #1;
        bready = 1'b0;
        @(negedge aclk); #1;
        check("wr_bvalid_clr", bvalid, 0);
        check("wr_pulse_count", pulses - p0, e ? 0 : 1);
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] p);
        bit e;
        int idx;
        e = m_err(a, p);
        idx = (a / 4) % 16;
        @(negedge aclk);
        araddr = a; arprot = p; arvalid = 1'b1;
        wait_ready("rd", 0, 0, 1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        @(negedge aclk);
        check("rd_rvalid", rvalid, 1);
        check("rd_rresp", rresp, e ? 2'b10 : 2'b00);
        check("rd_rdata", rdata, e ? 32'h0 : m_regs[idx]);
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        @(negedge aclk);
        check("rd_rvalid_clr", rvalid, 0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [1:0]  hold_resp;
        int p0;
        for (int i = 0; i < 16; i++) m_regs[i] = '0;

        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rdata", rdata, 0);
        check("rst_reg_wr", reg_wr_o, 0);
        check("rst_ready", {awready, wready, arready}, 3'b111);
        check_all("rst_reg");

        wr(32'h08, 3'b000, 32'hDEADBEEF, 4'hF);
        rd(32'h08, 3'b000);

        wr(32'h04, 3'b000, 32'hAAAAAAAA, 4'hF);
        @(negedge aclk);
        wdata = 32'h12345678; wstrb = 4'h3; wvalid = 1'b1; bready = 1'b1;
        wait_ready("wfirst", 0, 1, 0);
        @(posedge aclk); #1;
        wvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            check("wfirst_no_bvalid", bvalid, 0);
        end
        awaddr = 32'h04; awprot = 3'b000; awvalid = 1'b1;
        check("wfirst_awready", awready, 1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        @(negedge aclk);
        check("wfirst_bvalid_t1", bvalid, 0);
        @(negedge aclk);
        check("wfirst_bvalid_t2", bvalid, 1);
        m_regs[1] = merge(m_regs[1], 32'h12345678, 4'h3);
        check("wfirst_val", reg_o[63:32], 32'hAAAA5678);
        @(posedge aclk); #1;
        bready = 1'b0;

        rd(32'h100, 3'b000);
        wr(32'h100, 3'b000, 32'hFFFFFFFF, 4'hF);
        check_all("oor_unchanged");

        @(negedge aclk);
        awaddr = 32'h10; awvalid = 1'b1; wdata = 32'h0BADF00D; wstrb = 4'hF;
        wvalid = 1'b1; bready = 1'b0;
        wait_ready("stall", 1, 1, 0);
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        check("stall_bvalid", bvalid, 1);
        m_regs[4] = 32'h0BADF00D;
        hold_resp = bresp;
        awaddr = 32'h14; awvalid = 1'b1; wdata = 32'hCAFEBABE; wvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            check("stall_ready", {awready, wready}, 2'b00);
            check("stall_bvalid_hold", bvalid, 1);
            check("stall_bresp_hold", bresp, hold_resp);
        end
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        @(negedge aclk);
        check("stall_accept", {awready, wready}, 2'b11);
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        check("stall_2nd_bvalid", bvalid, 1);
        m_regs[5] = 32'hCAFEBABE;
        check_all("stall_regs");
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;

        wr(32'h0C, 3'b000, 32'h1, 4'hF);
        @(negedge aclk);
        awaddr = 32'h0C; awvalid = 1'b1; wdata = 32'h2; wstrb = 4'hF; wvalid = 1'b1;
        wait_ready("race", 1, 1, 0);
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge aclk);
        araddr = 32'h0C; arprot = 3'b000; arvalid = 1'b1;
        check("race_arready", arready, 1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        @(negedge aclk);
        check("race_bvalid", bvalid, 1);
        check("race_rvalid", rvalid, 1);
        check("race_old_data", rdata, 32'h1);
        m_regs[3] = 32'h2;
        bready = 1'b1; rready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0; rready = 1'b0;
        rd(32'h0C, 3'b000);

        wr(32'h00, 3'b000, 32'h55667788, 4'h0);

`ifdef AXIL_REG_FILE_PROT_EN
        wr(32'h24, 3'b000, 32'h99999999, 4'hF);
        check("prot_noupd", reg_o[9*32 +: 32], m_regs[9]);
        wr(32'h24, 3'b001, 32'h99999999, 4'hF);
        check("prot_upd", reg_o[9*32 +: 32], 32'h99999999);
        rd(32'h24, 3'b000);
        rd(32'h24, 3'b001);
`endif

        for (int t = 0; t < 60; t++) begin
            ra = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) ra = ra | (32'h1 << $urandom_range(6, 31));
            if ($urandom_range(0, 1) == 1)
                wr(ra, 3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
            else
                rd(ra, 3'($urandom_range(0, 7)));
        end
        check_all("rand_final");

        @(negedge aclk);
        awaddr = 32'h18; awvalid = 1'b1; wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 32'h08; arvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(posedge aclk); #2;
        aresetn = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        check("arst_bvalid", bvalid, 0);
        check("arst_rvalid", rvalid, 0);
        check("arst_rdata", rdata, 0);
        check("arst_reg_wr", reg_wr_o, 0);
        check_all("arst_regs");
        p0 = pulses;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("arst_ready", {awready, wready, arready}, 3'b111);
        repeat (3) @(negedge aclk);
        check("arst_no_resp", {bvalid, rvalid}, 2'b00);
        #1;
        check("arst_no_pulse", pulses - p0, 0);
        rd(32'h18, 3'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
